// File: rtl/adf4159_spi_monitor_pkg.sv
// rtl/adf4159_spi_monitor_pkg.sv - shared word width, register indices and address type for the ADF4159 SPI monitor
package ADF4159_PKG;

    localparam int WORD_WIDTH  = 32;
    localparam int COUNT_WIDTH = 6;

    typedef logic [2:0] regAddr_t;

    localparam regAddr_t R0_FRAC_INT  = 3'd0;
    localparam regAddr_t R1_LSB_FRAC  = 3'd1;
    localparam regAddr_t R2_R_DIV     = 3'd2;
    localparam regAddr_t R3_FUNCTION  = 3'd3;
    localparam regAddr_t R4_CLOCK     = 3'd4;
    localparam regAddr_t R5_DEVIATION = 3'd5;
    localparam regAddr_t R6_STEP      = 3'd6;
    localparam regAddr_t R7_DELAY     = 3'd7;

    // The ADF4159 control bits sit in the three LSBs of every word.
    function automatic regAddr_t wordAddress(input logic [WORD_WIDTH-1:0] word);
        return word[2:0];
    endfunction

endpackage

// File: rtl/adf4159_spi_monitor_if.sv
// rtl/adf4159_spi_monitor_if.sv - three-wire write-only SPI bus to the ADF4159
interface adf4159_spi_monitor_if;
    logic sClk;
    logic data;
    logic latch;

    modport master (output sClk, output data, output latch);
    modport slave  (input  sClk, input  data, input  latch);
endinterface

// File: rtl/adf4159_spi_sync.sv
// rtl/adf4159_spi_sync.sv - synchroniser plus registered rising-edge detect for one SPI line
module adf4159_spi_sync #(
    parameter int STAGES = 2
) (
    input  logic ipClk,
    input  logic ipReset,
    input  logic ipLine,
    output logic opLevel,
    output logic opRise
);
    logic [STAGES:0]   pipe;
    logic [STAGES+1:0] primed;

    // primed[k] marks that pipe[k] (and, at the top bit, opLevel) holds a real
    // post-reset sample, so a line already high at reset release is not an edge.
    always_ff @(posedge ipClk) begin
        if (ipReset) begin
            pipe    <= '0;
            primed  <= '0;
            opLevel <= 1'b0;
            opRise  <= 1'b0;
        end else begin
            pipe    <= {pipe[STAGES-1:0], ipLine};
            primed  <= {primed[STAGES:0], 1'b1};
            opLevel <= pipe[STAGES];
            opRise  <= pipe[STAGES] & ~opLevel & primed[STAGES+1];
        end
    end
endmodule

// File: rtl/adf4159_spi_monitor.sv
// rtl/adf4159_spi_monitor.sv - passive ADF4159 SPI word receiver with address decode
// Optional shadow register file when ADF4159_MONITOR_SHADOW_EN is defined.
module adf4159_spi_monitor
    import ADF4159_PKG::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic                  ipClk,
    input  logic                  ipReset,
    adf4159_spi_monitor_if.slave  spi,
    output logic                  opValid,
    output regAddr_t              opAddress,
    output logic [WORD_WIDTH-1:0] opData,
    output logic                  opError,
    output logic [15:0]           opWordCount
`ifdef ADF4159_MONITOR_SHADOW_EN
    ,
    input  regAddr_t              ipRdAddress,
    output logic [WORD_WIDTH-1:0] opRdData,
    output logic [7:0]            opWritten
`endif
);
    logic sClkLevel, sClkRise;
    logic dataLevel, dataRise;
    logic latchLevel, latchRise;
    logic unusedLines;

    adf4159_spi_sync #(.STAGES(SYNC_STAGES)) uSyncSClk (
        .ipClk(ipClk), .ipReset(ipReset), .ipLine(spi.sClk),
        .opLevel(sClkLevel), .opRise(sClkRise)
    );
    adf4159_spi_sync #(.STAGES(SYNC_STAGES)) uSyncData (
        .ipClk(ipClk), .ipReset(ipReset), .ipLine(spi.data),
        .opLevel(dataLevel), .opRise(dataRise)
    );
    adf4159_spi_sync #(.STAGES(SYNC_STAGES)) uSyncLatch (
        .ipClk(ipClk), .ipReset(ipReset), .ipLine(spi.latch),
        .opLevel(latchLevel), .opRise(latchRise)
    );

    assign unusedLines = sClkLevel ^ dataRise;

    logic [WORD_WIDTH-1:0]  shiftReg;
    logic [COUNT_WIDTH-1:0] bitCount;
    logic [15:0]            wordCount;
    logic                   accept;

    assign accept      = latchRise && (bitCount >= COUNT_WIDTH'(WORD_WIDTH));
    assign opWordCount = wordCount;

    // A latch edge takes priority: any SClk edge seen in the same cycle is dropped.
    always_ff @(posedge ipClk) begin
        if (ipReset) begin
            shiftReg  <= '0;
            bitCount  <= '0;
            wordCount <= '0;
            opValid   <= 1'b0;
            opError   <= 1'b0;
            opAddress <= '0;
            opData    <= '0;
        end else begin
            opValid <= 1'b0;
            opError <= 1'b0;
            if (latchRise) begin
                bitCount <= '0;
                if (accept) begin
                    opValid   <= 1'b1;
                    opData    <= shiftReg;
                    opAddress <= wordAddress(shiftReg);
                    wordCount <= wordCount + 16'd1;
                end else begin
                    opError <= 1'b1;
                end
            end else if (sClkRise && !latchLevel) begin
                shiftReg <= {shiftReg[WORD_WIDTH-2:0], dataLevel};
                if (bitCount != '1) begin
                    bitCount <= bitCount + 1'b1;
                end
            end
        end
    end

`ifdef ADF4159_MONITOR_SHADOW_EN
    logic [WORD_WIDTH-1:0] shadow [8];

    // Written on the same edge that raises opValid, so the registered read
    // shows the new value on the cycle after the strobe.
    always_ff @(posedge ipClk) begin
        if (ipReset) begin
            for (int i = 0; i < 8; i++) begin
                shadow[i] <= '0;
            end
            opWritten <= '0;
            opRdData  <= '0;
        end else begin
            if (accept) begin
                shadow[wordAddress(shiftReg)]    <= shiftReg;
                opWritten[wordAddress(shiftReg)] <= 1'b1;
            end
            opRdData <= shadow[ipRdAddress];
        end
    end
`endif
endmodule

// File: tb/tb_adf4159_spi_monitor.sv
// tb/tb_adf4159_spi_monitor.sv - scoreboard bench for the ADF4159 SPI monitor
module tb_adf4159_spi_monitor;
    import ADF4159_PKG::*;

    logic ipClk = 1'b0;
    logic ipReset = 1'b1;
    always #5 ipClk = ~ipClk;

    adf4159_spi_monitor_if spiBus();

    logic        opValid, opError;
    regAddr_t    opAddress;
    logic [31:0] opData;
    logic [15:0] opWordCount;
`ifdef ADF4159_MONITOR_SHADOW_EN
    regAddr_t    ipRdAddress = 3'd0;
    logic [31:0] opRdData;
    logic [7:0]  opWritten;
`endif

    adf4159_spi_monitor #(.SYNC_STAGES(2)) dut (
        .ipClk(ipClk),
        .ipReset(ipReset),
        .spi(spiBus.slave),
        .opValid(opValid),
        .opAddress(opAddress),
        .opData(opData),
        .opError(opError),
        .opWordCount(opWordCount)
`ifdef ADF4159_MONITOR_SHADOW_EN
        ,
        .ipRdAddress(ipRdAddress),
        .opRdData(opRdData),
        .opWritten(opWritten)
`endif
    );

    typedef struct {
        logic        isError;
        logic [31:0] data;
        logic [2:0]  addr;
        logic [15:0] count;
        int          latchCyc;
    } exp_t;

    exp_t        expQ[$];
    exp_t        monE;
    int          checkCount = 0;
    int          failCount = 0;
    int          cyc = 0;
    logic [31:0] modelData = '0;
    logic [2:0]  modelAddr = '0;
    logic [15:0] modelCount = '0;

    always @(posedge ipClk) cyc <= cyc + 1;

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] req);
        checkCount++;
        if (act !== req) begin
            failCount++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    always @(negedge ipClk) begin
        if (!ipReset && (opValid || opError)) begin
            if (expQ.size() == 0) begin
                checkCount++;
                failCount++;
                $display("FAIL unexpected_event: valid=%0b error=%0b, expected no event", opValid, opError);
            end else begin
                monE = expQ.pop_front();
                checkVal("strobe_kind", {30'd0, opValid, opError}, monE.isError ? 32'd1 : 32'd2);
                checkVal("data", opData, monE.data);
                checkVal("address", {29'd0, opAddress}, {29'd0, monE.addr});
                checkVal("word_count", {16'd0, opWordCount}, {16'd0, monE.count});
                checkVal("latency", cyc - monE.latchCyc, 32'd4);
            end
        end
    end

    task automatic shiftBits(input logic [63:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            spiBus.data = v[i];
            repeat (2) @(negedge ipClk);
            spiBus.sClk = 1'b1;
            repeat (3) @(negedge ipClk);
            spiBus.sClk = 1'b0;
            repeat (2) @(negedge ipClk);
        end
    endtask

    task automatic pulseLatch(input int nBits, input logic [31:0] word, input int toggles);
        exp_t e;
        @(negedge ipClk);
        if (nBits >= 32) begin
            modelData  = word;
            modelAddr  = word[2:0];
            modelCount = modelCount + 16'd1;
            e.isError  = 1'b0;
        end else begin
            e.isError  = 1'b1;
        end
        e.data     = modelData;
        e.addr     = modelAddr;
        e.count    = modelCount;
        e.latchCyc = cyc + 1;
        expQ.push_back(e);
        spiBus.latch = 1'b1;
        repeat (3) @(negedge ipClk);
        for (int t = 0; t < toggles; t++) begin
            spiBus.data = 1'b1;
            spiBus.sClk = 1'b1;
            repeat (3) @(negedge ipClk);
            spiBus.sClk = 1'b0;
            repeat (3) @(negedge ipClk);
        end
        spiBus.latch = 1'b0;
        repeat (10) @(negedge ipClk);
    endtask

    task automatic sendWord(input logic [63:0] v, input int n, input int toggles);
        shiftBits(v, n);
        pulseLatch(n, v[31:0], toggles);
    endtask

    initial begin
        spiBus.sClk  = 1'b0;
        spiBus.data  = 1'b0;
        spiBus.latch = 1'b0;
        ipReset = 1'b1;
        repeat (4) @(negedge ipClk);
        checkVal("reset_valid", {31'd0, opValid}, 32'd0);
        checkVal("reset_error", {31'd0, opError}, 32'd0);
        checkVal("reset_address", {29'd0, opAddress}, 32'd0);
        checkVal("reset_data", opData, 32'd0);
        checkVal("reset_count", {16'd0, opWordCount}, 32'd0);
        ipReset = 1'b0;
        repeat (4) @(negedge ipClk);

        sendWord(64'h0000_0000_1234_5670, 32, 0);
`ifdef ADF4159_MONITOR_SHADOW_EN
        ipRdAddress = 3'd0;
        repeat (2) @(negedge ipClk);
        checkVal("shadow_r0", opRdData, 32'h1234_5670);
        checkVal("shadow_written", {24'd0, opWritten}, 32'h01);
`endif
        sendWord(64'h0000_0000_000A_BCDE, 20, 0);
        sendWord(64'h0000_0000_0000_0007, 32, 0);
        sendWord(64'h0000_00A5_DEAD_BEE5, 40, 0);
        sendWord(64'h0000_0000_89AB_CDE6, 32, 3);
        sendWord(64'h0000_0000_0F0F_0F01, 32, 0);

        shiftBits(64'h0000_0000_0000_FFFF, 16);
        ipReset = 1'b1;
        repeat (3) @(negedge ipClk);
        checkVal("midword_reset_data", opData, 32'd0);
        checkVal("midword_reset_count", {16'd0, opWordCount}, 32'd0);
        ipReset = 1'b0;
        modelData  = '0;
        modelAddr  = '0;
        modelCount = '0;
        repeat (4) @(negedge ipClk);
        sendWord(64'h0000_0000_0000_0003, 32, 0);

        ipReset = 1'b1;
        spiBus.latch = 1'b1;
        repeat (3) @(negedge ipClk);
        ipReset = 1'b0;
        modelData  = '0;
        modelAddr  = '0;
        modelCount = '0;
        repeat (10) @(negedge ipClk);
        spiBus.latch = 1'b0;
        repeat (10) @(negedge ipClk);
        checkVal("latch_high_at_release_count", {16'd0, opWordCount}, 32'd0);
        sendWord(64'h0000_0000_CAFE_F00A, 32, 0);

        @(negedge ipClk);
        force dut.wordCount = 16'hFFFE;
        @(negedge ipClk);
        release dut.wordCount;
        modelCount = 16'hFFFE;
        sendWord(64'h0000_0000_1111_1114, 32, 0);
        sendWord(64'h0000_0000_2222_2220, 32, 0);

        for (int i = 0; i < 200 && expQ.size() != 0; i++) @(negedge ipClk);
        checkVal("queue_drained", expQ.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end
endmodule
